// File: rtl/alarm_mode_controller.sv
// alarm_mode_controller
//   Mode FSM for the MM:SS alarm clock. Gates the time counter's count enable,
//   issues one-cycle load pulses after a time edit, edits the time/alarm value
//   from debounced button pulses, stores the alarm and drives the buzzer.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   tick_1hz          one-cycle pulse per second (same tick as the counter)
//   btn_*             one-cycle debounced pulses: center, left, right, up, down
//   alarm_en          level switch; low disables and cancels the alarm
//   cur_*             current time digits from the counter chain
//   count_en          enable to the seconds-units counter (registered)
//   load, ld_*        one-cycle load pulse and load digits (registered)
//   disp_*            display digits: edit buffer in SET states, else current time
//   blink_min/sec     field under edit (registered)
//   mode              0 RUN, 1 SET_TIME, 2 SET_ALARM, 3 RINGING
//   buzzer            high while RINGING (registered)
module alarm_mode_controller #(
  parameter int RING_TICKS   = 30,
  parameter int EDIT_TIMEOUT = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_center,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       alarm_en,
  input  logic [2:0] cur_min_tens,
  input  logic [3:0] cur_min_units,
  input  logic [2:0] cur_sec_tens,
  input  logic [3:0] cur_sec_units,
  output logic       count_en,
  output logic       load,
  output logic [2:0] ld_min_tens,
  output logic [3:0] ld_min_units,
  output logic [2:0] ld_sec_tens,
  output logic [3:0] ld_sec_units,
  output logic [2:0] disp_min_tens,
  output logic [3:0] disp_min_units,
  output logic [2:0] disp_sec_tens,
  output logic [3:0] disp_sec_units,
  output logic       blink_min,
  output logic       blink_sec,
  output logic [1:0] mode,
  output logic       buzzer
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    SET_TIME  = 2'd1,
    SET_ALARM = 2'd2,
    RINGING   = 2'd3
  } state_t;

  typedef struct packed {
    logic [2:0] min_tens;
    logic [3:0] min_units;
    logic [2:0] sec_tens;
    logic [3:0] sec_units;
  } mmss_t;

  localparam logic       FLD_MIN   = 1'b0;
  localparam logic       FLD_SEC   = 1'b1;
  localparam logic [7:0] ECNT_LAST = 8'(EDIT_TIMEOUT - 1);
  localparam logic [7:0] RCNT_LAST = 8'(RING_TICKS - 1);

  // {tens,units} field 00..59, wraps both ways; no carry into the other field
  function automatic logic [6:0] fld_up(input logic [6:0] f);
    logic [2:0] t;
    logic [3:0] u;
    t = f[6:4];
    u = f[3:0];
    if (u == 4'd9) begin
      u = 4'd0;
      t = (t == 3'd5) ? 3'd0 : t + 3'd1;
    end else begin
      u = u + 4'd1;
    end
    return {t, u};
  endfunction

  function automatic logic [6:0] fld_dn(input logic [6:0] f);
    logic [2:0] t;
    logic [3:0] u;
    t = f[6:4];
    u = f[3:0];
    if (u == 4'd0) begin
      u = 4'd9;
      t = (t == 3'd0) ? 3'd5 : t - 3'd1;
    end else begin
      u = u - 4'd1;
    end
    return {t, u};
  endfunction

  function automatic mmss_t bump(input mmss_t v, input logic fld, input logic up);
    mmss_t r;
    r = v;
    if (fld == FLD_MIN)
      {r.min_tens, r.min_units} = up ? fld_up({v.min_tens, v.min_units})
                                     : fld_dn({v.min_tens, v.min_units});
    else
      {r.sec_tens, r.sec_units} = up ? fld_up({v.sec_tens, v.sec_units})
                                     : fld_dn({v.sec_tens, v.sec_units});
    return r;
  endfunction

  state_t     state_q, nxt_state;
  logic       field_q, nxt_field;
  mmss_t      edit_q, nxt_edit;
  mmss_t      alarm_q, nxt_alarm;
  mmss_t      ld_q, nxt_ld;
  logic       nxt_load;
  logic [7:0] ecnt_q, nxt_ecnt;
  logic [7:0] rcnt_q, nxt_rcnt;
  logic       match_d, nxt_match_d;
  mmss_t      cur;
  logic       match, any_btn, editing, nxt_editing;

  assign cur         = {cur_min_tens, cur_min_units, cur_sec_tens, cur_sec_units};
  assign match       = (cur == alarm_q);
  assign any_btn     = btn_center | btn_left | btn_right | btn_up | btn_down;
  assign editing     = (state_q == SET_TIME) || (state_q == SET_ALARM);
  assign nxt_editing = (nxt_state == SET_TIME) || (nxt_state == SET_ALARM);

  always_comb begin
    nxt_state   = state_q;
    nxt_field   = field_q;
    nxt_edit    = edit_q;
    nxt_alarm   = alarm_q;
    nxt_ld      = ld_q;
    nxt_load    = 1'b0;
    nxt_ecnt    = ecnt_q;
    nxt_rcnt    = rcnt_q;
    nxt_match_d = match;
    case (state_q)
      RUN: begin
        // Buttons take precedence over a same-cycle alarm trigger.
        if (btn_center) begin
          nxt_state = SET_TIME;
          nxt_edit  = cur;
          nxt_field = FLD_MIN;
          nxt_ecnt  = '0;
        end else if (btn_right) begin
          nxt_state = SET_ALARM;
          nxt_edit  = alarm_q;
          nxt_field = FLD_MIN;
          nxt_ecnt  = '0;
        end else if (alarm_en && match && !match_d) begin
          nxt_state = RINGING;
          nxt_rcnt  = '0;
        end
      end
      SET_TIME, SET_ALARM: begin
        if (btn_center) begin
          nxt_state = RUN;
          if (state_q == SET_TIME) begin
            nxt_load = 1'b1;
            nxt_ld   = edit_q;
          end else begin
            nxt_alarm = edit_q;
            // Pre-arm the edge detector with the new alarm so an alarm equal
            // to the time at commit does not ring immediately.
            nxt_match_d = (cur == edit_q);
          end
        end else if (btn_left) begin
          nxt_field = FLD_MIN;
          nxt_ecnt  = '0;
        end else if (btn_right) begin
          nxt_field = FLD_SEC;
          nxt_ecnt  = '0;
        end else if (btn_up) begin
          nxt_edit = bump(edit_q, field_q, 1'b1);
          nxt_ecnt = '0;
        end else if (btn_down) begin
          nxt_edit = bump(edit_q, field_q, 1'b0);
          nxt_ecnt = '0;
        end else if (tick_1hz) begin
          if (ecnt_q == ECNT_LAST) nxt_state = RUN;
          else                     nxt_ecnt  = ecnt_q + 8'd1;
        end
      end
      default: begin
        // RINGING: a button press is consumed only to cancel.
        if (any_btn || !alarm_en) begin
          nxt_state = RUN;
        end else if (tick_1hz) begin
          if (rcnt_q == RCNT_LAST) nxt_state = RUN;
          else                     nxt_rcnt  = rcnt_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      field_q   <= FLD_MIN;
      edit_q    <= '0;
      alarm_q   <= '0;
      ld_q      <= '0;
      load      <= 1'b0;
      ecnt_q    <= '0;
      rcnt_q    <= '0;
      // Treat time==alarm at power-up as already seen: no ring out of reset.
      match_d   <= 1'b1;
      count_en  <= 1'b0;
      buzzer    <= 1'b0;
      blink_min <= 1'b0;
      blink_sec <= 1'b0;
    end else begin
      state_q   <= nxt_state;
      field_q   <= nxt_field;
      edit_q    <= nxt_edit;
      alarm_q   <= nxt_alarm;
      ld_q      <= nxt_ld;
      load      <= nxt_load;
      ecnt_q    <= nxt_ecnt;
      rcnt_q    <= nxt_rcnt;
      match_d   <= nxt_match_d;
      count_en  <= (nxt_state != SET_TIME);
      buzzer    <= (nxt_state == RINGING);
      blink_min <= nxt_editing && (nxt_field == FLD_MIN);
      blink_sec <= nxt_editing && (nxt_field == FLD_SEC);
    end
  end

  assign mode = state_q;
  assign {ld_min_tens, ld_min_units, ld_sec_tens, ld_sec_units} = ld_q;
  assign {disp_min_tens, disp_min_units, disp_sec_tens, disp_sec_units} =
    editing ? edit_q : cur;

endmodule

// File: tb/tb_alarm_mode_controller.sv
module tb_alarm_mode_controller;
  localparam int RING_TICKS   = 30;
  localparam int EDIT_TIMEOUT = 20;
  localparam logic [4:0] C = 5'b10000, L = 5'b01000, R = 5'b00100,
                         U = 5'b00010, D = 5'b00001;

  logic clk = 0, reset = 0, tick_1hz = 0, alarm_en = 1;
  logic btn_center = 0, btn_left = 0, btn_right = 0, btn_up = 0, btn_down = 0;
  logic [2:0] cur_min_tens, cur_sec_tens, ld_min_tens, ld_sec_tens, disp_min_tens, disp_sec_tens;
  logic [3:0] cur_min_units, cur_sec_units, ld_min_units, ld_sec_units, disp_min_units, disp_sec_units;
  logic count_en, load, blink_min, blink_sec, buzzer;
  logic [1:0] mode;

  int cur_s = 0;
  logic force_en = 0;
  int force_val = 0;

  always #5 clk = ~clk;

  alarm_mode_controller #(.RING_TICKS(RING_TICKS), .EDIT_TIMEOUT(EDIT_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
    .btn_center(btn_center), .btn_left(btn_left), .btn_right(btn_right),
    .btn_up(btn_up), .btn_down(btn_down), .alarm_en(alarm_en),
    .cur_min_tens(cur_min_tens), .cur_min_units(cur_min_units),
    .cur_sec_tens(cur_sec_tens), .cur_sec_units(cur_sec_units),
    .count_en(count_en), .load(load),
    .ld_min_tens(ld_min_tens), .ld_min_units(ld_min_units),
    .ld_sec_tens(ld_sec_tens), .ld_sec_units(ld_sec_units),
    .disp_min_tens(disp_min_tens), .disp_min_units(disp_min_units),
    .disp_sec_tens(disp_sec_tens), .disp_sec_units(disp_sec_units),
    .blink_min(blink_min), .blink_sec(blink_sec), .mode(mode), .buzzer(buzzer));

  function automatic int to_s(input logic [2:0] mt, input logic [3:0] mu,
                              input logic [2:0] st, input logic [3:0] su);
    return (int'(mt) * 10 + int'(mu)) * 60 + int'(st) * 10 + int'(su);
  endfunction

  always_comb begin
    cur_min_tens  = 3'((cur_s / 60) / 10);
    cur_min_units = 4'((cur_s / 60) % 10);
    cur_sec_tens  = 3'((cur_s % 60) / 10);
    cur_sec_units = 4'((cur_s % 60) % 10);
  end

  // Environment: the mod-10/mod-6 counter chain as a seconds count.
  always @(posedge clk or posedge reset) begin
    if (reset)                      cur_s <= 0;
    else if (force_en)              cur_s <= force_val;
    else if (load)                  cur_s <= to_s(ld_min_tens, ld_min_units, ld_sec_tens, ld_sec_units);
    else if (count_en && tick_1hz)  cur_s <= (cur_s + 1) % 3600;
  end

  // Reference model: times held as seconds-of-hour, fields as minute/second numbers.
  typedef struct { logic [6:0] outs; bit dbuf; int dval; } exp_t;
  exp_t exp_q[$];
  int   ld_q[$];
  int   m_st, m_fld, m_buf, m_alarm, m_ecnt, m_rcnt;
  bit   m_md;

  function automatic int bump(input int v, input int fld, input int d);
    int mm, ss;
    mm = v / 60;
    ss = v % 60;
    if (fld == 0) mm = (mm + d + 60) % 60;
    else          ss = (ss + d + 60) % 60;
    return mm * 60 + ss;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_st = 0; m_fld = 0; m_buf = 0; m_alarm = 0; m_ecnt = 0; m_rcnt = 0; m_md = 1;
      exp_q.delete();
      ld_q.delete();
    end else begin : step
      int now;
      bit match, nmd, ld_now, anyb, ed;
      exp_t e;
      now    = cur_s;
      match  = (now == m_alarm);
      nmd    = match;
      ld_now = 0;
      anyb   = btn_center | btn_left | btn_right | btn_up | btn_down;
      case (m_st)
        0: begin
          if (btn_center)     begin m_st = 1; m_buf = now;     m_fld = 0; m_ecnt = 0; end
          else if (btn_right) begin m_st = 2; m_buf = m_alarm; m_fld = 0; m_ecnt = 0; end
          else if (alarm_en && match && !m_md) begin m_st = 3; m_rcnt = 0; end
        end
        1, 2: begin
          if (btn_center) begin
            if (m_st == 1) begin ld_now = 1; ld_q.push_back(m_buf); end
            else begin m_alarm = m_buf; nmd = (now == m_buf); end
            m_st = 0;
          end
          else if (btn_left)  begin m_fld = 0; m_ecnt = 0; end
          else if (btn_right) begin m_fld = 1; m_ecnt = 0; end
          else if (btn_up)    begin m_buf = bump(m_buf, m_fld, 1);  m_ecnt = 0; end
          else if (btn_down)  begin m_buf = bump(m_buf, m_fld, -1); m_ecnt = 0; end
          else if (tick_1hz) begin
            m_ecnt++;
            if (m_ecnt == EDIT_TIMEOUT) m_st = 0;
          end
        end
        default: begin
          if (anyb || !alarm_en) m_st = 0;
          else if (tick_1hz) begin
            m_rcnt++;
            if (m_rcnt == RING_TICKS) m_st = 0;
          end
        end
      endcase
      m_md = nmd;
      ed = (m_st == 1) || (m_st == 2);
      e.outs = {2'(m_st), (m_st != 1), ld_now, (m_st == 3), (ed && m_fld == 0), (ed && m_fld == 1)};
      e.dbuf = ed;
      e.dval = m_buf;
      exp_q.push_back(e);
    end
  end

  // Monitor / scoreboard
  int checks = 0, errors = 0, rd = 0, rd_ld = 0;
  bit rst_seen = 0, done = 0;

  function automatic void chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d @%0t", nm, got, want, $time);
    end
  endfunction

  always begin : monitor
    exp_t e;
    int dexp;
    @(negedge clk or posedge reset);
    if (reset) begin
      if (!rst_seen) begin
        rst_seen = 1;
        #1;
        chk("reset_outs", int'({mode, count_en, load, buzzer, blink_min, blink_sec}), 0);
        chk("reset_disp", to_s(disp_min_tens, disp_min_units, disp_sec_tens, disp_sec_units), 0);
        chk("reset_ld", to_s(ld_min_tens, ld_min_units, ld_sec_tens, ld_sec_units), 0);
      end
      rd = 0;
      rd_ld = 0;
    end else begin
      rst_seen = 0;
      if (rd < exp_q.size()) begin
        e = exp_q[rd];
        rd++;
        chk("outs{mode,cen,load,buz,bm,bs}",
            int'({mode, count_en, load, buzzer, blink_min, blink_sec}), int'(e.outs));
        dexp = e.dbuf ? e.dval : cur_s;
        chk("disp", to_s(disp_min_tens, disp_min_units, disp_sec_tens, disp_sec_units), dexp);
      end else begin
        chk("expect_queue_entries", exp_q.size(), rd + 1);
      end
      if (load) begin
        if (rd_ld < ld_q.size()) begin
          chk("ld_value", to_s(ld_min_tens, ld_min_units, ld_sec_tens, ld_sec_units), ld_q[rd_ld]);
          rd_ld++;
        end else begin
          chk("unexpected_load", 1, 0);
        end
      end
      if (done) begin
        chk("loads_issued", rd_ld, ld_q.size());
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  // Stimulus
  task automatic cyc(input logic [4:0] b, input logic t);
    @(negedge clk);
    {btn_center, btn_left, btn_right, btn_up, btn_down} = b;
    tick_1hz = t;
  endtask

  task automatic press(input logic [4:0] b);
    cyc(b, 1'b0);
    cyc(5'b0, 1'b0);
  endtask

  task automatic tk(input int n);
    repeat (n) begin
      cyc(5'b0, 1'b1);
      cyc(5'b0, 1'b0);
    end
  endtask

  task automatic force_cur(input int v);
    @(negedge clk);
    {btn_center, btn_left, btn_right, btn_up, btn_down} = '0;
    tick_1hz  = 0;
    force_en  = 1;
    force_val = v;
    @(negedge clk);
    force_en = 0;
  endtask

  initial begin
    logic [4:0] b;
    #1 reset = 1;
    repeat (2) @(negedge clk);
    #2 reset = 0;
    cyc(5'b0, 1'b0);

    // Time edit: 12:34 -> 14:59 with a single load
    force_cur(12 * 60 + 34);
    press(C);
    repeat (2) press(U);
    press(R);
    repeat (35) press(D);
    press(C);
    repeat (3) cyc(5'b0, 1'b0);

    // Alarm 00:05, ring from 00:00, auto-clear after RING_TICKS
    force_cur(0);
    press(R);
    press(R);
    repeat (5) press(U);
    press(C);
    tk(5);
    tk(RING_TICKS + 2);

    // Cancel by button, then by alarm_en
    force_cur(4);
    tk(1);
    cyc(5'b0, 1'b0);
    press(U);
    force_cur(4);
    tk(1);
    cyc(5'b0, 1'b0);
    @(negedge clk) alarm_en = 0;
    @(negedge clk) alarm_en = 1;
    cyc(5'b0, 1'b0);

    // Field wrap both ways, commit
    force_cur(59);
    press(C);
    press(R);
    press(U);
    press(D);
    press(C);
    // Center + up together in RUN: enter edit, buffer untouched
    press(C | U);
    // Edit timeout: back to RUN, no load, time resumes
    tk(EDIT_TIMEOUT);
    tk(2);

    // Async reset in the middle of SET_ALARM
    press(R);
    @(posedge clk);
    #3 reset = 1;
    repeat (2) @(negedge clk);
    #2 reset = 0;
    cyc(5'b0, 1'b0);

    // Random phase, occasionally steering the time just below the alarm
    repeat (3000) begin
      if ($urandom_range(0, 149) == 0) force_cur((m_alarm + 3599) % 3600);
      b = '0;
      for (int k = 0; k < 5; k++) if ($urandom_range(0, 11) == 0) b[k] = 1'b1;
      alarm_en = ($urandom_range(0, 39) != 0);
      cyc(b, $urandom_range(0, 3) == 0);
    end
    alarm_en = 1;
    repeat (4) cyc(5'b0, 1'b0);
    done = 1;
  end
endmodule
